// File: rtl/mag_diff_cmp_pkg.sv
// Shared types and constants for the registered magnitude comparator.
// Optional signed compare is selected in mag_diff_cmp with MAG_DIFF_CMP_SIGNED_EN.
package mag_diff_cmp_pkg;

  localparam int CMP_WIDTH = 16;
  localparam int CMP_IDX_W = $clog2(CMP_WIDTH);

  typedef struct packed {
    logic                 eq;
    logic                 ae;
    logic                 gt;
    logic [CMP_IDX_W-1:0] d;
  } cmp_result_t;

  localparam cmp_result_t CMP_RESULT_RST = '0;

  // ae is built from eq and gt, so ae == eq | gt always holds.
  function automatic cmp_result_t cmp_pack(input logic                 eq,
                                           input logic                 gt,
                                           input logic [CMP_IDX_W-1:0] d);
    cmp_result_t r;
    r.eq = eq;
    r.gt = gt;
    r.ae = eq | gt;
    r.d  = d;
    return r;
  endfunction

endpackage

// File: rtl/mag_diff_cmp_msb_diff_enc.sv
// Combinational priority encoder: reports whether any bit of x is set and
// the index of the highest set bit (0 when x is all zero).
module msb_diff_enc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         x,
  output logic                     any,
  output logic [$clog2(WIDTH)-1:0] idx
);

  localparam int IDX_W = $clog2(WIDTH);

  // Ascending scan: the last set bit seen wins, which is the most significant one.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) idx = IDX_W'(i);
    end
  end

  assign any = |x;

endmodule

// File: rtl/mag_diff_cmp.sv
// Registered magnitude comparator: eq/ae/gt flags plus index of the most
// significant differing bit. Define MAG_DIFF_CMP_SIGNED_EN for two's-complement operands.
module mag_diff_cmp
  import mag_diff_cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     out_valid,
  output logic                     eq,
  output logic                     ae,
  output logic                     gt,
  output logic [$clog2(WIDTH)-1:0] d
);

  localparam int IDX_W = $clog2(WIDTH);

  // Handshake: valid-only, no ready. Operands are taken on every edge where
  // in_valid is high; out_valid pulses for one cycle on the following cycle.
  // Between pulses the result flags hold the last accepted compare.

  logic [WIDTH-1:0] x;
  logic             any;
  logic [IDX_W-1:0] idx;
  logic             eq_c;
  logic             gt_c;
  cmp_result_t      res_c;
  cmp_result_t      res_q;
  logic             valid_q;

  assign x = a ^ b;

  msb_diff_enc #(
    .WIDTH(WIDTH)
  ) u_enc (
    .x  (x),
    .any(any),
    .idx(idx)
  );

  assign eq_c = ~any;

`ifdef MAG_DIFF_CMP_SIGNED_EN
  // A difference in the sign bit means the operand with the sign bit clear is larger.
  always_comb begin
    gt_c = 1'b0;
    if (!eq_c) begin
      if (idx == IDX_W'(WIDTH - 1)) gt_c = b[WIDTH-1];
      else                          gt_c = a[idx];
    end
  end
`else
  always_comb begin
    gt_c = 1'b0;
    if (!eq_c) gt_c = a[idx];
  end
`endif

  assign res_c = cmp_pack(eq_c, gt_c, idx);

  // Result capture is gated by in_valid so idle (possibly unknown) operands never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= CMP_RESULT_RST;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) res_q <= res_c;
    end
  end

  assign out_valid = valid_q;
  assign eq        = res_q.eq;
  assign ae        = res_q.ae;
  assign gt        = res_q.gt;
  assign d         = res_q.d;

endmodule

// File: tb/tb_mag_diff_cmp.sv
// Directed bench for mag_diff_cmp: arithmetic reference model checked every
// cycle, expected-result queue, plus hand-computed literal expectations.
module tb_mag_diff_cmp;

  localparam int W  = 16;
  localparam int IW = 4;
  localparam int RW = 3 + IW;

`ifdef MAG_DIFF_CMP_SIGNED_EN
  localparam logic SGN = 1'b1;
`else
  localparam logic SGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          eq;
  logic          ae;
  logic          gt;
  logic [IW-1:0] d;

  int n_checks = 0;
  int n_pass   = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp_hold  = '0;
  logic          exp_valid = 1'b0;
  logic          started   = 1'b0;

  mag_diff_cmp dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .eq       (eq),
    .ae       (ae),
    .gt       (gt),
    .d        (d)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    int   x;
    int   md;
    logic meq;
    logic mgt;
    logic mae;
    x   = int'(ma ^ mb);
    meq = (ma == mb);
    if (SGN) begin
      mgt = $signed(ma) >  $signed(mb);
      mae = $signed(ma) >= $signed(mb);
    end else begin
      mgt = ma >  mb;
      mae = ma >= mb;
    end
    md = meq ? 0 : $clog2(x + 1) - 1;
    return {meq, mae, mgt, IW'(md)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_hold  <= '0;
      exp_valid <= 1'b0;
    end else if (in_valid) begin
      exp_hold  <= model(a, b);
      exp_valid <= 1'b1;
      exp_q.push_back(model(a, b));
    end else begin
      exp_valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (started) begin
      logic [RW-1:0] got;
      got = {eq, ae, gt, d};
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("result",    32'(got),       32'(exp_hold));
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("queue_underflow", 32'(got), 32'hFFFF_FFFF);
        else                   chk("queue_result",    32'(got), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [W-1:0] va, input logic [W-1:0] vb, input logic v);
    @(negedge clk);
    a        = va;
    b        = vb;
    in_valid = v;
  endtask

  task automatic lit(input string name, input logic ov, input logic leq, input logic lae,
                     input logic lgt, input logic [IW-1:0] ld);
    @(posedge clk);
    #1;
    chk({name, "_ov"}, 32'(out_valid), 32'(ov));
    chk({name, "_eq"}, 32'(eq),        32'(leq));
    chk({name, "_ae"}, 32'(ae),        32'(lae));
    chk({name, "_gt"}, 32'(gt),        32'(lgt));
    chk({name, "_d"},  32'(d),         32'(ld));
  endtask

  logic [W-1:0] tbl_a[6] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8001, 16'hA5A5};
  logic [W-1:0] tbl_b[6] = '{16'h1334, 16'h0000, 16'h0001, 16'h8000, 16'h8000, 16'hA5A4};

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ov", 32'(out_valid), 32'd0);
    chk("reset_flags", 32'({eq, ae, gt, d}), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    started = 1'b1;

    apply(16'hD3DB, 16'hD3DB, 1'b1);
    lit("equal", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);

    apply(16'h53DB, 16'hD3DB, 1'b1);
    lit("msb_diff", 1'b1, 1'b0, SGN, SGN, 4'd15);

    apply(16'h0005, 16'h0004, 1'b1);
    lit("low_bit", 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);

    apply('x, 'x, 1'b0);
    lit("hold_x", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    apply(16'h0000, 16'hFFFF, 1'b0);
    lit("hold_new", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);

    for (int i = 0; i < 6; i++) apply(tbl_a[i], tbl_b[i], 1'b1);
    apply(16'h0000, 16'h0000, 1'b0);
    repeat (2) @(negedge clk);

    // Back-to-back with reset on the second edge: result 2 must be dropped.
    apply(16'h8000, 16'h7FFF, 1'b1);
    lit("b2b_first", 1'b1, 1'b0, ~SGN, ~SGN, 4'd15);
    apply(16'h0001, 16'h0001, 1'b1);
    rst = 1'b1;
    lit("b2b_reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    apply(16'h00F0, 16'h0F00, 1'b1);
    rst = 1'b0;
    lit("b2b_third", 1'b1, 1'b0, 1'b0, 1'b0, 4'd11);

    apply(16'h0000, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
